// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard sequencer and its mult/div tracker.
package hazard_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MULT = 2'd1,
        DIV  = 2'd2
    } md_state_t;

    localparam int MULT_CYCLES = 4;
    localparam int DIV_CYCLES  = 16;

    localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES - 1);
    localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES - 1);

    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_W  = 2'b01;
    localparam logic [1:0] FWD_M  = 2'b10;

    // The youngest producer (memory stage) wins when both later stages match.
    function automatic logic [1:0] fwd_sel(input logic [3:0] ea,
                                           input logic [3:0] ma3,
                                           input logic       mwe3,
                                           input logic [3:0] wa3,
                                           input logic       wwe3);
        if (mwe3 && (ma3 == ea))
            return FWD_M;
        if (wwe3 && (wa3 == ea))
            return FWD_W;
        return FWD_RF;
    endfunction

endpackage

// File: rtl/md_sequencer.sv
// Multiply/divide occupancy tracker: a down-counter that holds busy for the unit latency.
//   state | meaning
//   IDLE  | no operation in flight, accepts start
//   MULT  | multiply in progress, count runs MULT_CYCLES-1 .. 0
//   DIV   | divide in progress, count runs DIV_CYCLES-1 .. 0
module md_sequencer
    import hazard_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic div,
    output logic busy,
    output logic done
);

    md_state_t  state;
    md_state_t  state_next;
    logic [3:0] count;
    logic [3:0] count_next;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            count <= 4'd0;
        end else begin
            state <= state_next;
            count <= count_next;
        end
    end

    always_comb begin
        state_next = state;
        count_next = count;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = div ? DIV : MULT;
                    count_next = div ? DIV_LOAD : MULT_LOAD;
                end
            end
            MULT, DIV: begin
                if (count == 4'd0) begin
                    state_next = IDLE;
                    count_next = 4'd0;
                end else begin
                    count_next = count - 4'd1;
                end
            end
            default: begin
                state_next = IDLE;
                count_next = 4'd0;
            end
        endcase
    end

    // Outputs are held low while reset is asserted, not just after the edge.
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        if (!reset && (state != IDLE)) begin
            busy = 1'b1;
            done = (count == 4'd0);
        end
    end

endmodule

// File: rtl/hazard_sequencer.sv
// Pipeline stall/flush and operand-forwarding control; HAZARD_FORWARD_EN enables bypassing,
// otherwise any pending register write into a decode source stalls.
module hazard_sequencer
    import hazard_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] Da1,
    input  logic [3:0] Da2,
    input  logic [3:0] Ea1,
    input  logic [3:0] Ea2,
    input  logic [3:0] Ea3,
    input  logic       Ewe3,
    input  logic       Eload,
    input  logic [3:0] Ma3,
    input  logic       Mwe3,
    input  logic [3:0] Wa3,
    input  logic       Wwe3,
    input  logic       Dmdstart,
    input  logic       Dhiloread,
    input  logic       Emdstart,
    input  logic       Ediv,
    output logic       stallF,
    output logic       stallD,
    output logic       flushE,
    output logic [1:0] forwardAE,
    output logic [1:0] forwardBE,
    output logic       md_busy,
    output logic       md_done
);

    logic       md_hazard;
    logic       lu_hazard;
    logic       raw_hazard;
    logic       stall;
    logic [1:0] fwd_a;
    logic [1:0] fwd_b;

    md_sequencer u_md (
        .clk   (clk),
        .reset (reset),
        .start (Emdstart),
        .div   (Ediv),
        .busy  (md_busy),
        .done  (md_done)
    );

`ifndef HAZARD_FORWARD_EN
    logic unused_fwd_srcs;
    assign unused_fwd_srcs = ^{Ea1, Ea2};
`endif

    always_comb begin
        // The done cycle is when hi/lo is written, so a waiting reader may proceed.
        md_hazard = (Dmdstart | Dhiloread) & (md_busy | Emdstart) & ~md_done;
        lu_hazard = Eload & Ewe3 & ((Ea3 == Da1) | (Ea3 == Da2));
`ifdef HAZARD_FORWARD_EN
        raw_hazard = 1'b0;
        fwd_a      = fwd_sel(Ea1, Ma3, Mwe3, Wa3, Wwe3);
        fwd_b      = fwd_sel(Ea2, Ma3, Mwe3, Wa3, Wwe3);
`else
        raw_hazard = (Ewe3 & ((Ea3 == Da1) | (Ea3 == Da2)))
                   | (Mwe3 & ((Ma3 == Da1) | (Ma3 == Da2)))
                   | (Wwe3 & ((Wa3 == Da1) | (Wa3 == Da2)));
        fwd_a      = FWD_RF;
        fwd_b      = FWD_RF;
`endif
        stall = ~reset & (md_hazard | lu_hazard | raw_hazard);
    end

    assign stallF    = stall;
    assign stallD    = stall;
    assign flushE    = stall;
    assign forwardAE = reset ? FWD_RF : fwd_a;
    assign forwardBE = reset ? FWD_RF : fwd_b;

endmodule

// File: tb/tb_hazard_sequencer.sv
// Scoreboard bench for hazard_sequencer; expectations adapt to whether HAZARD_FORWARD_EN is defined.
module tb_hazard_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] Da1, Da2, Ea1, Ea2, Ea3, Ma3, Wa3;
    logic       Ewe3, Eload, Mwe3, Wwe3;
    logic       Dmdstart, Dhiloread, Emdstart, Ediv;
    logic       stallF, stallD, flushE;
    logic [1:0] forwardAE, forwardBE;
    logic       md_busy, md_done;

    logic [8:0] obs;
    logic [8:0] exp_v;
    logic [8:0] exp_q[$];
    int         n_cmp = 0;
    int         n_bad = 0;

`ifdef HAZARD_FORWARD_EN
    localparam bit FWD_ON = 1'b1;
`else
    localparam bit FWD_ON = 1'b0;
`endif

    always #5 clk = ~clk;

    hazard_sequencer dut (
        .clk       (clk),
        .reset     (reset),
        .Da1       (Da1),
        .Da2       (Da2),
        .Ea1       (Ea1),
        .Ea2       (Ea2),
        .Ea3       (Ea3),
        .Ewe3      (Ewe3),
        .Eload     (Eload),
        .Ma3       (Ma3),
        .Mwe3      (Mwe3),
        .Wa3       (Wa3),
        .Wwe3      (Wwe3),
        .Dmdstart  (Dmdstart),
        .Dhiloread (Dhiloread),
        .Emdstart  (Emdstart),
        .Ediv      (Ediv),
        .stallF    (stallF),
        .stallD    (stallD),
        .flushE    (flushE),
        .forwardAE (forwardAE),
        .forwardBE (forwardBE),
        .md_busy   (md_busy),
        .md_done   (md_done)
    );

    // {stallF, stallD, flushE, forwardAE, forwardBE, md_busy, md_done}
    assign obs = {stallF, stallD, flushE, forwardAE, forwardBE, md_busy, md_done};

    function automatic logic [8:0] mk(input logic s, input logic [1:0] fa, input logic [1:0] fb,
                                      input logic b, input logic d);
        return {s, s, s, fa, fb, b, d};
    endfunction

    task automatic clear_inputs();
        Da1 = 4'd0; Da2 = 4'd0; Ea1 = 4'd0; Ea2 = 4'd0; Ea3 = 4'd0; Ma3 = 4'd0; Wa3 = 4'd0;
        Ewe3 = 1'b0; Eload = 1'b0; Mwe3 = 1'b0; Wwe3 = 1'b0;
        Dmdstart = 1'b0; Dhiloread = 1'b0; Emdstart = 1'b0; Ediv = 1'b0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        clear_inputs();
        Wwe3 = 1'b1; Wa3 = 4'd7; Da1 = 4'd7;
        Mwe3 = 1'b1; Ma3 = 4'd5; Ea1 = 4'd5; Ea2 = 4'd5;
        Dhiloread = 1'b1; Emdstart = 1'b1;
        exp_q.push_back(mk(1'b0, 2'b00, 2'b00, 1'b0, 1'b0));
        @(negedge clk);
        exp_v = exp_q.pop_front(); n_cmp++;
        if (obs !== exp_v) begin
            n_bad++; $display("FAIL reset_forced: got %b expected %b", obs, exp_v);
        end
        next_cycle();
        clear_inputs();
        reset = 1'b0;
        exp_q.push_back(mk(1'b0, 2'b00, 2'b00, 1'b0, 1'b0));
        @(negedge clk);
        exp_v = exp_q.pop_front(); n_cmp++;
        if (obs !== exp_v) begin
            n_bad++; $display("FAIL post_reset_idle: got %b expected %b", obs, exp_v);
        end
        next_cycle();
    endtask

    task automatic test_forward();
        clear_inputs();
        Mwe3 = 1'b1; Ma3 = 4'd5; Wwe3 = 1'b1; Wa3 = 4'd5; Ea1 = 4'd5;
        exp_q.push_back(mk(1'b0, FWD_ON ? 2'b10 : 2'b00, 2'b00, 1'b0, 1'b0));
        @(negedge clk);
        exp_v = exp_q.pop_front(); n_cmp++;
        if (obs !== exp_v) begin
            n_bad++; $display("FAIL fwd_m_wins: got %b expected %b", obs, exp_v);
        end
        next_cycle();
        Mwe3 = 1'b0;
        exp_q.push_back(mk(1'b0, FWD_ON ? 2'b01 : 2'b00, 2'b00, 1'b0, 1'b0));
        @(negedge clk);
        exp_v = exp_q.pop_front(); n_cmp++;
        if (obs !== exp_v) begin
            n_bad++; $display("FAIL fwd_w_only: got %b expected %b", obs, exp_v);
        end
        next_cycle();
        Mwe3 = 1'b1; Ea2 = 4'd5;
        exp_q.push_back(mk(1'b0, FWD_ON ? 2'b10 : 2'b00, FWD_ON ? 2'b10 : 2'b00, 1'b0, 1'b0));
        @(negedge clk);
        exp_v = exp_q.pop_front(); n_cmp++;
        if (obs !== exp_v) begin
            n_bad++; $display("FAIL fwd_both_m: got %b expected %b", obs, exp_v);
        end
        next_cycle();
        Ma3 = 4'd6; Ea2 = 4'd6;
        exp_q.push_back(mk(1'b0, FWD_ON ? 2'b01 : 2'b00, FWD_ON ? 2'b10 : 2'b00, 1'b0, 1'b0));
        @(negedge clk);
        exp_v = exp_q.pop_front(); n_cmp++;
        if (obs !== exp_v) begin
            n_bad++; $display("FAIL fwd_split: got %b expected %b", obs, exp_v);
        end
        next_cycle();
        clear_inputs();
    endtask

    task automatic test_raw();
        clear_inputs();
        Wwe3 = 1'b1; Wa3 = 4'd7; Da1 = 4'd7;
        exp_q.push_back(mk(!FWD_ON, 2'b00, 2'b00, 1'b0, 1'b0));
        @(negedge clk);
        exp_v = exp_q.pop_front(); n_cmp++;
        if (obs !== exp_v) begin
            n_bad++; $display("FAIL raw_w: got %b expected %b", obs, exp_v);
        end
        next_cycle();
        clear_inputs();
        Mwe3 = 1'b1; Ma3 = 4'd9; Da2 = 4'd9;
        exp_q.push_back(mk(!FWD_ON, 2'b00, 2'b00, 1'b0, 1'b0));
        @(negedge clk);
        exp_v = exp_q.pop_front(); n_cmp++;
        if (obs !== exp_v) begin
            n_bad++; $display("FAIL raw_m: got %b expected %b", obs, exp_v);
        end
        next_cycle();
        clear_inputs();
        Ewe3 = 1'b1; Ea3 = 4'd2; Da1 = 4'd2; Ea1 = 4'd8; Ea2 = 4'd8;
        exp_q.push_back(mk(!FWD_ON, 2'b00, 2'b00, 1'b0, 1'b0));
        @(negedge clk);
        exp_v = exp_q.pop_front(); n_cmp++;
        if (obs !== exp_v) begin
            n_bad++; $display("FAIL raw_e: got %b expected %b", obs, exp_v);
        end
        next_cycle();
        clear_inputs();
        Wwe3 = 1'b1; Wa3 = 4'd0; Da1 = 4'd0;
        exp_q.push_back(mk(!FWD_ON, FWD_ON ? 2'b01 : 2'b00, FWD_ON ? 2'b01 : 2'b00, 1'b0, 1'b0));
        @(negedge clk);
        exp_v = exp_q.pop_front(); n_cmp++;
        if (obs !== exp_v) begin
            n_bad++; $display("FAIL raw_reg0: got %b expected %b", obs, exp_v);
        end
        next_cycle();
        clear_inputs();
        Wwe3 = 1'b0; Wa3 = 4'd7; Da1 = 4'd7; Ea1 = 4'd7;
        exp_q.push_back(mk(1'b0, 2'b00, 2'b00, 1'b0, 1'b0));
        @(negedge clk);
        exp_v = exp_q.pop_front(); n_cmp++;
        if (obs !== exp_v) begin
            n_bad++; $display("FAIL raw_we_off: got %b expected %b", obs, exp_v);
        end
        next_cycle();
        clear_inputs();
    endtask

    task automatic test_load_use();
        clear_inputs();
        Eload = 1'b1; Ewe3 = 1'b1; Ea3 = 4'd3; Da2 = 4'd3; Da1 = 4'd1;
        exp_q.push_back(mk(1'b1, 2'b00, 2'b00, 1'b0, 1'b0));
        @(negedge clk);
        exp_v = exp_q.pop_front(); n_cmp++;
        if (obs !== exp_v) begin
            n_bad++; $display("FAIL lu_stall: got %b expected %b", obs, exp_v);
        end
        next_cycle();
        Eload = 1'b0; Ewe3 = 1'b0; Ea3 = 4'd0;
        exp_q.push_back(mk(1'b0, 2'b00, 2'b00, 1'b0, 1'b0));
        @(negedge clk);
        exp_v = exp_q.pop_front(); n_cmp++;
        if (obs !== exp_v) begin
            n_bad++; $display("FAIL lu_release: got %b expected %b", obs, exp_v);
        end
        next_cycle();
        Eload = 1'b1; Ewe3 = 1'b0; Ea3 = 4'd3;
        exp_q.push_back(mk(1'b0, 2'b00, 2'b00, 1'b0, 1'b0));
        @(negedge clk);
        exp_v = exp_q.pop_front(); n_cmp++;
        if (obs !== exp_v) begin
            n_bad++; $display("FAIL lu_no_we: got %b expected %b", obs, exp_v);
        end
        next_cycle();
        Ewe3 = 1'b1; Da1 = 4'd4; Da2 = 4'd5;
        exp_q.push_back(mk(1'b0, 2'b00, 2'b00, 1'b0, 1'b0));
        @(negedge clk);
        exp_v = exp_q.pop_front(); n_cmp++;
        if (obs !== exp_v) begin
            n_bad++; $display("FAIL lu_no_match: got %b expected %b", obs, exp_v);
        end
        next_cycle();
        clear_inputs();
    endtask

    task automatic test_div_hiloread();
        clear_inputs();
        Emdstart = 1'b1; Ediv = 1'b1; Dhiloread = 1'b1;
        exp_q.push_back(mk(1'b1, 2'b00, 2'b00, 1'b0, 1'b0));
        @(negedge clk);
        exp_v = exp_q.pop_front(); n_cmp++;
        if (obs !== exp_v) begin
            n_bad++; $display("FAIL div_start: got %b expected %b", obs, exp_v);
        end
        next_cycle();
        Emdstart = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            exp_q.push_back(mk(i < 16, 2'b00, 2'b00, 1'b1, i == 16));
            @(negedge clk);
            exp_v = exp_q.pop_front(); n_cmp++;
            if (obs !== exp_v) begin
                n_bad++; $display("FAIL div_busy_%0d: got %b expected %b", i, obs, exp_v);
            end
            next_cycle();
        end
        exp_q.push_back(mk(1'b0, 2'b00, 2'b00, 1'b0, 1'b0));
        @(negedge clk);
        exp_v = exp_q.pop_front(); n_cmp++;
        if (obs !== exp_v) begin
            n_bad++; $display("FAIL div_after: got %b expected %b", obs, exp_v);
        end
        next_cycle();
        clear_inputs();
    endtask

    task automatic test_mult_reset();
        clear_inputs();
        Emdstart = 1'b1; Ediv = 1'b0;
        for (int i = 0; i <= 6; i++) begin
            if (i == 1) Emdstart = 1'b0;
            reset = (i == 2);
            exp_q.push_back(mk(1'b0, 2'b00, 2'b00, i == 1, 1'b0));
            @(negedge clk);
            exp_v = exp_q.pop_front(); n_cmp++;
            if (obs !== exp_v) begin
                n_bad++; $display("FAIL mult_reset_c%0d: got %b expected %b", i, obs, exp_v);
            end
            next_cycle();
        end
        reset = 1'b0;
        clear_inputs();
    endtask

    task automatic test_back_to_back();
        clear_inputs();
        // c0: mult enters E while another md op waits in D
        // c5: second mult enters E; c7: stray start while busy must be ignored
        for (int i = 0; i <= 10; i++) begin
            Emdstart = (i == 0) || (i == 5) || (i == 7);
            Ediv     = (i == 7);
            Dmdstart = (i <= 4);
            exp_q.push_back(mk(i <= 3, 2'b00, 2'b00, (i >= 1 && i <= 4) || (i >= 6 && i <= 9),
                               (i == 4) || (i == 9)));
            @(negedge clk);
            exp_v = exp_q.pop_front(); n_cmp++;
            if (obs !== exp_v) begin
                n_bad++; $display("FAIL b2b_c%0d: got %b expected %b", i, obs, exp_v);
            end
            next_cycle();
        end
        clear_inputs();
    endtask

    initial begin
        test_reset();
        test_forward();
        test_raw();
        test_load_use();
        test_div_hiloread();
        test_mult_reset();
        test_back_to_back();
        if (exp_q.size() != 0) begin
            n_cmp++; n_bad++;
            $display("FAIL scoreboard_drain: got %0d entries left expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
